// File: rtl/bus_arbiter_4x1_if.sv
// Request/grant bus between up to four requesters and the 4x1 bus arbiter.
// The arbiter connects through the slave modport and the requester side through master.
interface bus_arbiter_4x1_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_arbiter_4x1.sv
// Round-robin owner arbiter for the shared 16-bit bus. It drives the one-hot grant and the mux select,
// inserts one dead cycle between owners and forcibly releases an owner after TIMEOUT cycles.
module bus_arbiter_4x1 #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input logic               clk,
  input logic               reset,
  bus_arbiter_4x1_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWN     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             timeout_q, timeout_d;

  logic [1:0] winner;
  logic       any_req;
  logic       release_own;

  // Walk from the farthest offset down to ptr so the closest request after ptr wins.
  always_comb begin
    winner  = ptr_q;
    any_req = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[ptr_q + 2'(i)]) begin
        winner  = ptr_q + 2'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    timeout_d   = 1'b0;
    release_own = bus.done[owner_q] || !bus.req[owner_q];

    case (state_q)
      ST_OWN: begin
        if (release_own || cnt_q == CNT_LAST) begin
          grant_d   = 4'b0000;
          ptr_d     = owner_q + 2'd1;
          state_d   = ST_RELEASE;
          // A voluntary release on the last cycle is not a timeout.
          timeout_d = !release_own;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and RELEASE arbitrate identically; RELEASE already sees the advanced pointer.
        grant_d = 4'b0000;
        state_d = ST_IDLE;
        if (any_req) begin
          state_d = ST_OWN;
          owner_d = winner;
          sel_d   = winner;
          grant_d = 4'b0001 << winner;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      cnt_q     <= '0;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = |grant_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_4x1.sv
// Scoreboard bench for bus_arbiter_4x1: the stimulus pushes the predictions of an owner/age reference model,
// and a monitor pops and compares them one cycle later. Directed phases are followed by random traffic.
module tb_bus_arbiter_4x1;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bus_arbiter_4x1_if bus ();

  bus_arbiter_4x1 #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: m_owner is -1 when nobody owns the bus; m_age is the number of cycles owned so far.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_age   = 0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".grant"},   8'(bus.grant),   8'(e.grant));
    check({tag, ".sel"},     8'(bus.sel),     8'(e.sel));
    check({tag, ".busy"},    8'(bus.busy),    8'(e.busy));
    check({tag, ".timeout"}, 8'(bus.timeout), 8'(e.timeout));
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_age   = 0;
    m_to    = 1'b0;
  endtask

  // An owner leaves on done, on dropping its request, or after TIMEOUT cycles of ownership.
  // Without an owner, the first requester at or after the pointer (cyclically) takes the bus.
  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    bit voluntary;
    if (m_owner >= 0) begin
      voluntary = d[m_owner] || !r[m_owner];
      if (voluntary || m_age == TIMEOUT - 1) begin
        m_to    = !voluntary;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_to  = 1'b0;
        m_age = m_age + 1;
      end
    end else begin
      m_to = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_last  = m_owner;
          m_age   = 0;
        end
      end
    end
  endtask

  function automatic logic [3:0] owner_mask();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  // Called at a falling edge: drive inputs, predict the next rising edge, then advance to the next falling edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    bus.req  = r;
    bus.done = d;
    model_step(r, d);
    e.grant   = owner_mask();
    e.sel     = 2'(m_last);
    e.busy    = (m_owner >= 0);
    e.timeout = m_to;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Reset is asserted between clock edges and checked before any edge, so it must act asynchronously.
  task automatic do_reset(input int n, input logic [3:0] r);
    exp_t z;
    z.grant   = 4'b0000;
    z.sel     = 2'd0;
    z.busy    = 1'b0;
    z.timeout = 1'b0;
    bus.req   = r;
    bus.done  = 4'b0000;
    reset     = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check_outputs("reset_async", z);
    repeat (n) begin
      @(negedge clk);
      check_outputs("reset_hold", z);
    end
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_outputs("cycle", e);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] g_trace[$];
    logic [1:0] s_trace[$];
    logic [3:0] g_want[9];
    logic [1:0] s_want[5];
    logic [3:0] last_g;
    logic [3:0] r;
    logic [3:0] d;
    int         hi;

    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    @(negedge clk);

    // Reset with all requests held, then round-robin with done on each owner's second cycle.
    do_reset(3, 4'b1111);
    last_g = 4'b0000;
    repeat (13) begin
      cycle(4'b1111, (m_age == 1) ? owner_mask() : 4'b0000);
      if (bus.grant !== last_g) begin
        g_trace.push_back(bus.grant);
        if (bus.grant !== 4'b0000) s_trace.push_back(bus.sel);
        last_g = bus.grant;
      end
    end
    g_want = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    s_want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check("rr_trace_len", 8'(g_trace.size()), 8'd9);
    for (int i = 0; i < 9; i++)
      check($sformatf("rr_grant[%0d]", i), (i < g_trace.size()) ? 8'(g_trace[i]) : 8'hff, 8'(g_want[i]));
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_sel[%0d]", i), (i < s_trace.size()) ? 8'(s_trace[i]) : 8'hff, 8'(s_want[i]));

    // Pointer skip: after requester 1 releases, 0011 must wrap around to requester 0.
    do_reset(2, 4'b0000);
    cycle(4'b0010, 4'b0000);
    cycle(4'b0010, 4'b0010);
    cycle(4'b0011, 4'b0000);
    check("ptr_skip_grant", 8'(bus.grant), 8'h01);
    cycle(4'b0011, 4'b0001);
    cycle(4'b0000, 4'b0000);

    // Timeout: grant held for exactly TIMEOUT cycles, a timeout pulse, then a re-grant.
    hi = 0;
    cycle(4'b0100, 4'b0000);
    while (bus.grant == 4'b0100 && hi < 40) begin
      hi++;
      cycle(4'b0100, 4'b0000);
    end
    check("timeout_grant_len", 8'(hi), 8'(TIMEOUT));
    check("timeout_pulse", 8'(bus.timeout), 8'h01);
    cycle(4'b0100, 4'b0000);
    check("timeout_regrant", 8'(bus.grant), 8'h04);

    // Done strobes from non-owners are ignored; the owner's own done releases without timeout.
    cycle(4'b0100, 4'b1011);
    cycle(4'b0100, 4'b1011);
    check("ignored_done", 8'(bus.grant), 8'h04);
    cycle(4'b0100, 4'b0100);
    check("done_release_to", 8'(bus.timeout), 8'h00);
    cycle(4'b0000, 4'b0000);

    // Done on the last allowed cycle counts as a normal release.
    cycle(4'b0001, 4'b0000);
    while (m_owner >= 0 && m_age < TIMEOUT - 1) cycle(4'b0001, 4'b0000);
    cycle(4'b0001, 4'b0001);
    check("done_at_limit_to", 8'(bus.timeout), 8'h00);
    cycle(4'b0000, 4'b0000);
    // Request drop together with done.
    cycle(4'b0010, 4'b0000);
    cycle(4'b0000, 4'b0010);
    cycle(4'b0000, 4'b0000);

    // Reset in the middle of requester 3's ownership, then arbitration restarts from pointer 0.
    do_reset(1, 4'b0000);
    cycle(4'b1000, 4'b0000);
    repeat (7) cycle(4'b1000, 4'b0000);
    do_reset(2, 4'b1010);
    cycle(4'b1010, 4'b0000);
    check("post_reset_grant", 8'(bus.grant), 8'h02);
    cycle(4'b1010, 4'b0010);

    // Random traffic with sticky requests so that timeouts also occur.
    r = 4'b0000;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      case ($urandom_range(0, 15))
        0, 1:    d = owner_mask();
        2:       d = 4'($urandom);
        default: d = 4'b0000;
      endcase
      if ($urandom_range(0, 599) == 0) do_reset(1, r);
      else cycle(r, d);
    end

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
